// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster outputs of the VGA timing generator, shared with the mapper stages.
interface vga_timing_gen_if;
   logic [9:0]  DrawX;
   logic [9:0]  DrawY;
   logic        blank;
   logic        hs;
   logic        vs;
   logic        line_start;
   logic        frame_start;
   logic [15:0] frame_count;

   modport master (
      output DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count
   );

   modport slave (
      input  DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count
   );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-rate raster counters with delayed blank/sync,
// line/frame strobes and a wrapping frame counter.
// H_TOTAL and V_TOTAL (parameter sums) must each be <= 1024 to fit the 10-bit counters.
module vga_timing_gen #(
   parameter int H_VISIBLE   = 640,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int V_VISIBLE   = 480,
   parameter int V_FP        = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 33,
   parameter int BLANK_DELAY = 1,
   parameter int SYNC_DELAY  = 2
) (
   input  logic             vga_clk,
   input  logic             reset_n,
   vga_timing_gen_if.master bus
);
   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
   localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FP);
   localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FP);
   localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

   logic [9:0]  hc_q, hc_d;
   logic [9:0]  vc_q, vc_d;
   logic        hc_wrap, frame_wrap;
   logic        line_start_q, frame_start_q;
   logic [15:0] frame_count_q;
   logic        vis_raw, hs_raw, vs_raw;

   // Next raster position: hc free-runs, vc steps only when hc wraps
   always_comb begin
      hc_wrap    = (hc_q == H_LAST);
      frame_wrap = hc_wrap && (vc_q == V_LAST);
      hc_d       = hc_wrap ? 10'd0 : hc_q + 10'd1;
      vc_d       = vc_q;
      if (hc_wrap) begin
         vc_d = (vc_q == V_LAST) ? 10'd0 : vc_q + 10'd1;
      end
   end

   // Counters, strobes (from next-state so they align with the counter value) and frame count
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         hc_q          <= 10'd0;
         vc_q          <= 10'd0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         frame_count_q <= 16'd0;
      end else begin
         hc_q          <= hc_d;
         vc_q          <= vc_d;
         line_start_q  <= (hc_d == 10'd0);
         frame_start_q <= (hc_d == 10'd0) && (vc_d == 10'd0);
         if (frame_wrap) begin
            frame_count_q <= frame_count_q + 16'd1;
         end
      end
   end

   // Undelayed decodes of the current raster position; syncs are active-low
   assign vis_raw = (hc_q < H_VIS) && (vc_q < V_VIS);
   assign hs_raw  = !((hc_q >= HS_BEG) && (hc_q <= HS_END));
   assign vs_raw  = !((vc_q >= VS_BEG) && (vc_q <= VS_END));

   generate
      if (BLANK_DELAY == 0) begin : g_blank_comb
         assign bus.blank = vis_raw;
      end else begin : g_blank_dly
         logic [BLANK_DELAY-1:0] blank_q;
         // Display-enable delay matching the mapper ROM latency
         always_ff @(posedge vga_clk or negedge reset_n) begin
            if (!reset_n) begin
               blank_q <= '0;
            end else begin
               blank_q[0] <= vis_raw;
               for (int i = 1; i < BLANK_DELAY; i++) begin
                  blank_q[i] <= blank_q[i-1];
               end
            end
         end
         assign bus.blank = blank_q[BLANK_DELAY-1];
      end

      if (SYNC_DELAY == 0) begin : g_sync_comb
         assign bus.hs = hs_raw;
         assign bus.vs = vs_raw;
      end else begin : g_sync_dly
         logic [SYNC_DELAY-1:0] hs_q;
         logic [SYNC_DELAY-1:0] vs_q;
         // Sync delay matching ROM plus RGB register latency; idle level is high
         always_ff @(posedge vga_clk or negedge reset_n) begin
            if (!reset_n) begin
               hs_q <= '1;
               vs_q <= '1;
            end else begin
               hs_q[0] <= hs_raw;
               vs_q[0] <= vs_raw;
               for (int i = 1; i < SYNC_DELAY; i++) begin
                  hs_q[i] <= hs_q[i-1];
                  vs_q[i] <= vs_q[i-1];
               end
            end
         end
         assign bus.hs = hs_q[SYNC_DELAY-1];
         assign bus.vs = vs_q[SYNC_DELAY-1];
      end
   endgenerate

   assign bus.DrawX       = hc_q;
   assign bus.DrawY       = vc_q;
   assign bus.line_start  = line_start_q;
   assign bus.frame_start = frame_start_q;
   assign bus.frame_count = frame_count_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen on a reduced raster
// (25 x 13 = 325 cycles per frame) with directed and random reset activity.
module tb_vga_timing_gen;
  localparam int HV = 16, HF = 2, HS = 4, HB = 3;
  localparam int VV = 6,  VF = 2, VS = 2, VB = 3;
  localparam int BD = 1,  SD = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int TIMEOUT_CYC = 200000;

  logic vga_clk = 1'b0;
  logic reset_n = 1'b0;

  vga_timing_gen_if vif();

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .BLANK_DELAY(BD), .SYNC_DELAY(SD)
  ) dut (
    .vga_clk(vga_clk),
    .reset_n(reset_n),
    .bus(vif.master)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        blank;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
    logic [15:0] fc;
  } obs_t;

  obs_t   sb[$];
  int     total = 0;
  int     bad   = 0;
  longint n     = 0;
  bit     in_rst = 1'b1;
  bit     done   = 1'b0;

  // Reference model: everything derived from m = cycles elapsed since reset release
  function automatic bit vis_at(longint m);
    return ((m % HT) < HV) && (((m / HT) % VT) < VV);
  endfunction

  function automatic bit hs_at(longint m);
    longint x = m % HT;
    return !((x >= HV + HF) && (x < HV + HF + HS));
  endfunction

  function automatic bit vs_at(longint m);
    longint y = (m / HT) % VT;
    return !((y >= VV + VF) && (y < VV + VF + VS));
  endfunction

  function automatic obs_t model(longint m);
    obs_t e;
    e.x     = 10'(m % HT);
    e.y     = 10'((m / HT) % VT);
    e.blank = (m >= BD) ? vis_at(m - BD) : 1'b0;
    e.hs    = (m >= SD) ? hs_at(m - SD) : 1'b1;
    e.vs    = (m >= SD) ? vs_at(m - SD) : 1'b1;
    e.ls    = (m > 0) && ((m % HT) == 0);
    e.fs    = (m > 0) && ((m % FT) == 0);
    e.fc    = 16'((m / FT) % 65536);
    return e;
  endfunction

  // One clock: reset_n changes 2 time units after the edge (asynchronously),
  // and the expectation for the rest of this cycle is queued.
  task automatic step(input logic rl);
    @(posedge vga_clk);
    #2;
    reset_n = rl;
    if (!rl) begin
      in_rst = 1'b1;
      n      = 0;
    end else if (in_rst) begin
      in_rst = 1'b0;
      n      = 0;
    end else begin
      n++;
    end
    #1;
    sb.push_back(model(n));
  endtask

  // Monitor: compares DUT outputs at the falling edge against the queued expectation
  always @(negedge vga_clk) begin
    if (sb.size() > 0) begin
      obs_t e;
      obs_t g;
      e = sb.pop_front();
      g = {vif.DrawX, vif.DrawY, vif.blank, vif.hs, vif.vs,
           vif.line_start, vif.frame_start, vif.frame_count};
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL raster got x=%0d y=%0d blank=%b hs=%b vs=%b ls=%b fs=%b fc=%0d required x=%0d y=%0d blank=%b hs=%b vs=%b ls=%b fs=%b fc=%0d",
                 g.x, g.y, g.blank, g.hs, g.vs, g.ls, g.fs, g.fc,
                 e.x, e.y, e.blank, e.hs, e.vs, e.ls, e.fs, e.fc);
      end
    end
  end

  // Watchdog: the stimulus must complete within a bounded number of cycles
  initial begin
    repeat (TIMEOUT_CYC) @(posedge vga_clk);
    if (!done) begin
      bad++;
      $display("FAIL timeout: stimulus not finished after %0d cycles", TIMEOUT_CYC);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    // Held reset, then direct reset-state check
    repeat (5) step(1'b0);
    total++;
    if (vif.DrawX !== 10'd0 || vif.DrawY !== 10'd0 || vif.hs !== 1'b1 ||
        vif.vs !== 1'b1 || vif.blank !== 1'b0 || vif.line_start !== 1'b0 ||
        vif.frame_start !== 1'b0 || vif.frame_count !== 16'd0) begin
      bad++;
      $display("FAIL reset state got x=%0d y=%0d hs=%b vs=%b blank=%b ls=%b fs=%b fc=%0d required x=0 y=0 hs=1 vs=1 blank=0 ls=0 fs=0 fc=0",
               vif.DrawX, vif.DrawY, vif.hs, vif.vs, vif.blank,
               vif.line_start, vif.frame_start, vif.frame_count);
    end
    // Release and run into the fourth frame
    repeat (3 * FT + 4 * HT + 10) step(1'b1);
    // Mid-frame asynchronous reset while frame_count = 3
    repeat (2) step(1'b0);
    // Random run lengths separated by random reset pulses
    for (int k = 0; k < 14; k++) begin
      int run_len;
      int rst_len;
      run_len = $urandom_range(4 * FT, 10);
      rst_len = $urandom_range(4, 1);
      repeat (run_len) step(1'b1);
      repeat (rst_len) step(1'b0);
    end
    // Final long run spanning several frame wraps
    repeat (3 * FT + 7) step(1'b1);
    @(posedge vga_clk);
    @(posedge vga_clk);
    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
